coo_edge_aggregation_ctrl: RTL and testbench

- Parametrised successor of the fixed six-edge GCN aggregation FSM.
- Walks a COO edge list and sequences the accesses for each edge:
  - reads the feature×weight product memory for each edge direction;
  - issues a write strobe to the adjacency-product accumulator.
- Sits between the COO edge memory / FM·W product buffer and the aggregation accumulator.
- Adds the following, which the earlier block lacked:
  - runtime edge count;
  - configurable read latency;
  - optional symmetric (two-direction) processing;
  - write backpressure;
  - re-armable start/busy/done handshake.

---
 rtl/gcn_ctrl_pkg.sv | 25 ++
 rtl/edge_counter.sv | 31 +++
 rtl/coo_edge_aggregation_ctrl.sv | 164 ++++++++++++++++
 tb/tb_coo_edge_aggregation_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gcn_ctrl_pkg.sv
// Shared types and constants for the GCN aggregation controllers.
// Holds the sequencer state encoding, pass encodings and the read-latency bound.
package gcn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } agg_state_t;

  localparam logic PASS_FWD = 1'b0;
  localparam logic PASS_REV = 1'b1;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 8;

  // States in which the product buffer is being read.
  function automatic logic is_access_state(input agg_state_t s);
    return (s == READ) || (s == WAIT) || (s == WRITE);
  endfunction

endpackage

// File: rtl/edge_counter.sv
// Edge index counter: synchronous clear, count enable, and a terminal-count
// flag against a runtime limit. Holds at the limit instead of wrapping.
module edge_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Count register; clear wins over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (en && (count_r != limit)) begin
      count_r <= count_r + W'(1);
    end
  end

  assign count = count_r;
  assign tc    = (count_r == limit);

endmodule

// File: rtl/coo_edge_aggregation_ctrl.sv
// COO edge-list walker: per edge, reads FM*W products for one or both
// directions and strobes the aggregation accumulator, with write backpressure.
module coo_edge_aggregation_ctrl
  import gcn_ctrl_pkg::*;
#(
  parameter int MAX_EDGES   = 64,
  parameter int EDGE_IDX_BW = $clog2(MAX_EDGES),
  parameter int CNT_BW      = $clog2(MAX_EDGES + 1),
  parameter int READ_LAT    = 1,
  parameter bit SYMMETRIC   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_BW-1:0]      num_edges,
  input  logic                   wr_ready,
  output logic [EDGE_IDX_BW-1:0] edge_idx,
  output logic                   rd_en,
  output logic                   rd_sel,
  output logic                   wr_en,
  output logic                   edge_inc,
  output logic                   busy,
  output logic                   done
);

  localparam int                 WAIT_BW   = $clog2(READ_LAT_MAX);
  localparam logic [WAIT_BW-1:0] WAIT_LAST = (READ_LAT > 1) ? WAIT_BW'(READ_LAT - 2) : '0;
  localparam logic [CNT_BW-1:0]  MAX_CNT   = CNT_BW'(MAX_EDGES);

  agg_state_t             state_r;
  agg_state_t             state_nx_s;
  logic                   pass_r;
  logic                   pass_nx_s;
  logic [CNT_BW-1:0]      cnt_r;
  logic [WAIT_BW-1:0]     wait_cnt_r;
  logic                   idx_clear_s;
  logic                   idx_en_s;
  logic                   idx_tc_s;
  logic [EDGE_IDX_BW-1:0] idx_limit_s;
  logic [EDGE_IDX_BW-1:0] idx_count_s;
  logic                   rd_en_r;
  logic                   rd_sel_r;
  logic                   wr_en_r;
  logic                   edge_inc_r;
  logic                   busy_r;
  logic                   done_r;

  assign idx_clear_s = (state_r == IDLE) && start;
  assign idx_en_s    = (state_r == NEXT) && !idx_tc_s;
  // cnt_r is at least 1 whenever the limit is consulted (NEXT only follows a non-empty start).
  assign idx_limit_s = EDGE_IDX_BW'(cnt_r - CNT_BW'(1));

  edge_counter #(
    .W (EDGE_IDX_BW)
  ) u_edge_counter (
    .clk   (clk),
    .reset (reset),
    .clear (idx_clear_s),
    .en    (idx_en_s),
    .limit (idx_limit_s),
    .count (idx_count_s),
    .tc    (idx_tc_s)
  );

  // Next-state and next-pass decode.
  always_comb begin
    state_nx_s = state_r;
    pass_nx_s  = pass_r;
    case (state_r)
      IDLE: begin
        if (!start) begin
          state_nx_s = IDLE;
        end else if (num_edges == '0) begin
          state_nx_s = DONE;
          pass_nx_s  = PASS_FWD;
        end else begin
          state_nx_s = READ;
          pass_nx_s  = PASS_FWD;
        end
      end
      READ: begin
        if (READ_LAT > 1) begin
          state_nx_s = WAIT;
        end else begin
          state_nx_s = WRITE;
        end
      end
      WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nx_s = WRITE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      WRITE: begin
        if (!wr_ready) begin
          state_nx_s = WRITE;
        end else if (SYMMETRIC && (pass_r == PASS_FWD)) begin
          state_nx_s = READ;
          pass_nx_s  = PASS_REV;
        end else begin
          state_nx_s = NEXT;
        end
      end
      NEXT: begin
        if (idx_tc_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = READ;
          pass_nx_s  = PASS_FWD;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        pass_nx_s  = PASS_FWD;
      end
    endcase
  end

  // FSM state, run count, wait counter and outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pass_r     <= PASS_FWD;
      cnt_r      <= '0;
      wait_cnt_r <= '0;
      rd_en_r    <= 1'b0;
      rd_sel_r   <= 1'b0;
      wr_en_r    <= 1'b0;
      edge_inc_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pass_r  <= pass_nx_s;
      if (idx_clear_s) begin
        cnt_r <= (num_edges > MAX_CNT) ? MAX_CNT : num_edges;
      end
      if (state_r == READ) begin
        wait_cnt_r <= '0;
      end else if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + WAIT_BW'(1);
      end
      rd_en_r    <= is_access_state(state_nx_s);
      rd_sel_r   <= is_access_state(state_nx_s) & pass_nx_s;
      wr_en_r    <= (state_nx_s == WRITE);
      edge_inc_r <= (state_nx_s == NEXT);
      done_r     <= (state_nx_s == DONE);
      busy_r     <= (state_nx_s != IDLE);
    end
  end

  assign edge_idx = idx_count_s;
  assign rd_en    = rd_en_r;
  assign rd_sel   = rd_sel_r;
  assign wr_en    = wr_en_r;
  assign edge_inc = edge_inc_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_coo_edge_aggregation_ctrl.sv
// Bench for coo_edge_aggregation_ctrl: two configurations, each run walked
// cycle by cycle against a timeline built from the per-edge access rules.
module tb_coo_edge_aggregation_ctrl;

  localparam int MAX_A = 64;
  localparam int LAT_A = 1;
  localparam int SYM_A = 1;
  localparam int MAX_B = 8;
  localparam int LAT_B = 3;
  localparam int SYM_B = 0;
  localparam int CBW_A = $clog2(MAX_A + 1);
  localparam int IBW_A = $clog2(MAX_A);
  localparam int CBW_B = $clog2(MAX_B + 1);
  localparam int IBW_B = $clog2(MAX_B);
  localparam logic [31:0] IDX_MASK = 32'h0000_003f;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_a = 1'b0;
  logic             start_b = 1'b0;
  logic             wr_ready = 1'b0;
  logic [CBW_A-1:0] num_edges = '0;

  logic [IBW_A-1:0] edge_idx_a;
  logic             rd_en_a, rd_sel_a, wr_en_a, edge_inc_a, busy_a, done_a;
  logic [IBW_B-1:0] edge_idx_b;
  logic             rd_en_b, rd_sel_b, wr_en_b, edge_inc_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  coo_edge_aggregation_ctrl #(
    .MAX_EDGES (MAX_A), .READ_LAT (LAT_A), .SYMMETRIC (1'b1)
  ) dut_a (
    .clk (clk), .reset (reset), .start (start_a), .num_edges (num_edges),
    .wr_ready (wr_ready), .edge_idx (edge_idx_a), .rd_en (rd_en_a),
    .rd_sel (rd_sel_a), .wr_en (wr_en_a), .edge_inc (edge_inc_a),
    .busy (busy_a), .done (done_a)
  );

  coo_edge_aggregation_ctrl #(
    .MAX_EDGES (MAX_B), .READ_LAT (LAT_B), .SYMMETRIC (1'b0)
  ) dut_b (
    .clk (clk), .reset (reset), .start (start_b), .num_edges (num_edges[CBW_B-1:0]),
    .wr_ready (wr_ready), .edge_idx (edge_idx_b), .rd_en (rd_en_b),
    .rd_sel (rd_sel_b), .wr_en (wr_en_b), .edge_inc (edge_inc_b),
    .busy (busy_b), .done (done_b)
  );

  function automatic logic [31:0] pack(input logic b, input logic d, input logic i,
                                       input logic w, input logic s, input logic r,
                                       input int idx);
    return {20'd0, b, d, i, w, s, r, idx[5:0]};
  endfunction

  function automatic logic [31:0] obs(input int which);
    if (which != 0)
      return pack(busy_b, done_b, edge_inc_b, wr_en_b, rd_sel_b, rd_en_b, int'(edge_idx_b));
    else
      return pack(busy_a, done_a, edge_inc_a, wr_en_a, rd_sel_a, rd_en_a, int'(edge_idx_a));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run: N edges, random backpressure (bp_pct % not-ready), stall0 forced
  // not-ready cycles on the very first write, optional held start, optional
  // reset at cycle abort_at (counted from the accepting edge).
  task automatic run(input int which, input int n, input int bp_pct, input int stall0,
                     input bit hold, input int abort_at);
    int lat, npass, maxe, neff, cyc;
    bit rdy;
    lat   = (which != 0) ? LAT_B : LAT_A;
    npass = (((which != 0) ? SYM_B : SYM_A) != 0) ? 2 : 1;
    maxe  = (which != 0) ? MAX_B : MAX_A;
    neff  = (n > maxe) ? maxe : n;
    num_edges = CBW_A'(n);
    if (which != 0) start_b = 1'b1; else start_a = 1'b1;
    wr_ready = 1'b0;
    step();
    cyc = 1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    num_edges = CBW_A'($urandom);
    for (int e = 0; e < neff; e++) begin
      for (int ps = 0; ps < npass; ps++) begin
        for (int l = 0; l < lat; l++) begin
          check("read", obs(which), pack(1'b1, 1'b0, 1'b0, 1'b0, ps[0], 1'b1, e));
          wr_ready = 1'($urandom);
          step();
          cyc++;
        end
        for (int s = 0; s < 20; s++) begin
          if (e == 0 && ps == 0 && stall0 > 0) rdy = (s >= stall0);
          else rdy = (s == 19) || ($urandom_range(99) >= bp_pct);
          check("write", obs(which), pack(1'b1, 1'b0, 1'b0, 1'b1, ps[0], 1'b1, e));
          if (cyc == abort_at) begin
            reset = 1'b1;
            #1;
            check("reset_mid", obs(which), 32'd0);
            step();
            check("reset_hold", obs(which), 32'd0);
            reset = 1'b0;
            wr_ready = 1'b0;
            step();
            check("after_reset_idle", obs(which), 32'd0);
            return;
          end
          wr_ready = rdy;
          step();
          cyc++;
          wr_ready = 1'b0;
          if (rdy) break;
        end
      end
      check("next", obs(which), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e));
      step();
      cyc++;
    end
    check("done", obs(which), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (neff > 0) ? neff - 1 : 0));
    step();
    check("idle", obs(which) & ~IDX_MASK, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", obs(0), 32'd0);
    check("reset_b", obs(1), 32'd0);
    reset = 1'b0;
    step();
    check("idle_a", obs(0), 32'd0);

    run(0, 3, 0, 0, 1'b0, -1);
    run(0, 3, 0, 2, 1'b0, -1);
    run(1, 2, 0, 0, 1'b0, -1);
    run(0, 0, 0, 0, 1'b0, -1);
    run(1, 0, 0, 0, 1'b0, -1);
    run(0, MAX_A + 5, 0, 0, 1'b0, -1);
    run(1, MAX_B + 5, 20, 0, 1'b0, -1);
    run(0, 3, 0, 0, 1'b0, 7);
    run(0, 3, 0, 0, 1'b0, -1);
    run(0, 2, 0, 0, 1'b1, -1);
    run(0, 3, 0, 0, 1'b0, -1);
    run(1, 3, 30, 0, 1'b1, -1);
    run(1, 1, 30, 0, 1'b0, -1);

    for (int k = 0; k < 14; k++) begin
      int which;
      which = int'($urandom_range(1));
      run(which, int'($urandom_range(0, ((which != 0) ? MAX_B : MAX_A) + 3)),
          int'($urandom_range(0, 60)), 0, 1'b0, -1);
      repeat (int'($urandom_range(0, 2))) begin
        step();
        check("gap_idle", obs(which) & ~IDX_MASK, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
